// File: rtl/uart_tx.sv
// Byte-serial UART transmitter: pops 32-bit words, sends BytesPerWord bytes LSB-first as 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit before STOP (11-bit frames).
module uart_tx #(
    parameter int unsigned BaudDiv      = 868,
    parameter int unsigned BytesPerWord = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        have_next,
    input  logic [31:0] data,
    output logic        next,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned     CntW     = $clog2(BaudDiv);
    localparam logic [CntW-1:0] CntLoad  = CntW'(BaudDiv - 1);
    localparam logic [1:0]      LastByte = 2'(BytesPerWord - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              next_q, next_d;
    logic              busy_q, busy_d;
    logic              bit_done;

    assign bit_done = (cnt_q == '0);

    // State and output registers; tx resets high so an aborted frame releases the line at once.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            next_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            next_q     <= next_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; outputs are derived from the state being entered so they line up with it.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q - CntW'(1);
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        next_d     = 1'b0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (have_next) begin
                    state_d    = START;
                    cnt_d      = CntLoad;
                    shift_d    = data;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                    next_d     = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    cnt_d     = CntLoad;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = CntLoad;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    cnt_d   = CntLoad;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (byte_idx_q != LastByte) begin
                        state_d    = START;
                        cnt_d      = CntLoad;
                        byte_idx_d = byte_idx_q + 2'd1;
                        shift_d    = {8'd0, shift_q[31:8]};
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = ^shift_d[7:0];
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign next = next_q;
    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx at BaudDiv=4 with one-byte and four-byte word instances.
module tb_uart_tx;

    localparam int Baud = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FrameBits = 11;
`else
    localparam int FrameBits = 10;
`endif
    localparam int FC = Baud * FrameBits;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hn1, hn4;
    logic [31:0] d1, d4;
    logic        nx1, nx4, tx1, tx4, bz1, bz4;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] word;
        logic [7:0]  exp_byte;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    uart_tx #(.BaudDiv(4), .BytesPerWord(1)) u_dut1 (
        .clk_i(clk), .reset_i(rst_n), .have_next(hn1), .data(d1),
        .next(nx1), .tx(tx1), .busy(bz1)
    );

    uart_tx #(.BaudDiv(4), .BytesPerWord(4)) u_dut4 (
        .clk_i(clk), .reset_i(rst_n), .have_next(hn4), .data(d4),
        .next(nx4), .tx(tx4), .busy(bz4)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
`ifdef UART_TX_PARITY_EN
        if (p == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_idle(input bit sel);
        int n = 0;
        while ((sel ? bz4 : bz1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check1("idle_wait", sel ? bz4 : bz1, 1'b0);
    endtask

    // Pulse have_next once, then check every cycle of the resulting frames against the scoreboard.
    task automatic run_word(input bit sel, input logic [31:0] word, input int nbytes);
        logic [7:0] cur = 8'h00;
        int c, p;
        @(negedge clk);
        if (sel) begin hn4 = 1'b1; d4 = word; end
        else     begin hn1 = 1'b1; d1 = word; end
        for (int k = 0; k < nbytes * FC; k++) begin
            @(negedge clk);
            c = k % FC;
            p = c / Baud;
            if (c == 0) begin
                check1("sb_avail", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
            end
            check1("next", sel ? nx4 : nx1, k == 0);
            check1("busy", sel ? bz4 : bz1, 1'b1);
            check1($sformatf("tx_bit%0d", p), sel ? tx4 : tx1, exp_bit(cur, p));
            if (sel) begin hn4 = 1'($urandom); d4 = $urandom; end
            else     begin hn1 = 1'($urandom); d1 = $urandom; end
        end
        @(negedge clk);
        check1("end_busy", sel ? bz4 : bz1, 1'b0);
        check1("end_tx", sel ? tx4 : tx1, 1'b1);
        check1("end_next", sel ? nx4 : nx1, 1'b0);
        if (sel) hn4 = 1'b0; else hn1 = 1'b0;
        @(negedge clk);
        check1("idle_next", sel ? nx4 : nx1, 1'b0);
        check1("idle_busy", sel ? bz4 : bz1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t1, t2, pulses, b2b;
        logic prev;
        logic [7:0] got;

        vecs[0] = '{32'h0000_00A5, 8'hA5};
        vecs[1] = '{32'hFFFF_FF07, 8'h07};
        vecs[2] = '{32'h1234_5603, 8'h03};
        vecs[3] = '{32'hFFFF_FF00, 8'h00};
        vecs[4] = '{32'h0000_00FF, 8'hFF};
        vecs[5] = '{32'h1234_5680, 8'h80};
        vecs[6] = '{32'hABCD_EF01, 8'h01};

        rst_n = 1'b0;
        hn1 = 1'b0; hn4 = 1'b0;
        d1 = 32'h0; d4 = 32'h0;
        repeat (3) @(negedge clk);
        check1("rst_tx1", tx1, 1'b1);
        check1("rst_busy1", bz1, 1'b0);
        check1("rst_next1", nx1, 1'b0);
        check1("rst_tx4", tx4, 1'b1);
        check1("rst_busy4", bz4, 1'b0);
        rst_n = 1'b1;

        // No pop while have_next stays low, whatever data does.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            d1 = $urandom;
            check1("quiet_tx", tx1, 1'b1);
            check1("quiet_next", nx1, 1'b0);
            check1("quiet_busy", bz1, 1'b0);
        end

        for (int i = 0; i < 7; i++) begin
            wait_idle(1'b0);
            exp_q.push_back(vecs[i].exp_byte);
            run_word(1'b0, vecs[i].word, 1);
        end

        wait_idle(1'b1);
        exp_q.push_back(8'h44); exp_q.push_back(8'h33);
        exp_q.push_back(8'h22); exp_q.push_back(8'h11);
        run_word(1'b1, 32'h1122_3344, 4);
        wait_idle(1'b1);
        exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
        exp_q.push_back(8'hAD); exp_q.push_back(8'hDE);
        run_word(1'b1, 32'hDEAD_BEEF, 4);
        check32("sb_left", 32'(exp_q.size()), 32'd0);

        // have_next held high over two words: two pops, FC+1 apart, second frame carries the new word.
        wait_idle(1'b0);
        t1 = -1; t2 = -1; pulses = 0; b2b = 0; prev = 1'b0; got = 8'h00;
        @(negedge clk);
        hn1 = 1'b1; d1 = 32'h0000_005A;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (nx1) begin
                pulses++;
                if (prev) b2b++;
                if (t1 < 0) begin
                    t1 = i; d1 = 32'h0000_00C3;
                end else if (t2 < 0) begin
                    t2 = i; hn1 = 1'b0;
                end
            end
            prev = nx1;
            for (int b = 0; b < 8; b++)
                if (t2 >= 0 && i == t2 + Baud * (1 + b) + 1) got[b] = tx1;
        end
        check32("pop_count", 32'(pulses), 32'd2);
        check32("pop_spacing", 32'(t2 - t1), 32'(FC + 1));
        check32("back_to_back", 32'(b2b), 32'd0);
        check32("second_byte", {24'd0, got}, 32'h0000_00C3);

        // Reset asserted during data bit 3 of 0xA5 (a 0 bit): line must go high immediately.
        wait_idle(1'b0);
        @(negedge clk);
        hn1 = 1'b1; d1 = 32'h0000_00A5;
        @(negedge clk);
        hn1 = 1'b0;
        repeat (Baud * 4) @(negedge clk);
        check1("pre_rst_tx", tx1, 1'b0);
        check1("pre_rst_busy", bz1, 1'b1);
        rst_n = 1'b0;
        #1;
        check1("abort_tx", tx1, 1'b1);
        check1("abort_busy", bz1, 1'b0);
        check1("abort_next", nx1, 1'b0);
        repeat (2) @(negedge clk);
        check1("hold_tx", tx1, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check1("post_rst_tx", tx1, 1'b1);
            check1("post_rst_busy", bz1, 1'b0);
            check1("post_rst_next", nx1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 Parameter BaudDiv, default 868, clock cycles per serial bit; the block SHALL accept any value >= 4.
- REQ-002 Parameter BytesPerWord, default 1, number of bytes sent per popped word; legal range 1..4.
- REQ-003 clk_i  input  1  single clock; all state SHALL be updated on its rising edge.
- REQ-004 reset_i  input  1  reset; asynchronous and active-low.
- REQ-005 have_next  input  1  upstream queue holds at least one word.
- REQ-006 data  input  32  word at the head of the upstream queue.
- REQ-007 next  output  1  one-cycle pop strobe to the upstream queue.
- REQ-008 tx  output  1  serial line; idles high.
- REQ-009 busy  output  1  high while a word is being serialized.

Function
- REQ-010 States SHALL be IDLE, START, DATA, PARITY (only when the macro in REQ-025 is defined), and STOP.
- REQ-011 In IDLE with have_next=1, the block SHALL latch data into a 32-bit shift register, assert next for exactly one cycle, and enter START on the same edge.
- REQ-012 next SHALL never be high in two consecutive cycles. After a pop, have_next SHALL be ignored until the block returns to IDLE; this tolerates the one-cycle-stale registered have_next from the upstream queue.
- REQ-013 The baud counter SHALL load BaudDiv-1 on every state or bit entry and decrement each cycle. A bit period SHALL end when the counter reads 0, so every bit lasts exactly BaudDiv cycles.
- REQ-014 In START, tx SHALL be 0 for one bit period, then the block SHALL enter DATA with bit index 0.
- REQ-015 In DATA, tx SHALL equal bit [bit index] of the current byte, LSB first. After bit 7 the block SHALL enter PARITY or STOP.
- REQ-016 In STOP, tx SHALL be 1 for one bit period.
- REQ-017 At the end of STOP, if byte index < BytesPerWord-1, the block SHALL increment the byte index, shift the register right by 8, and enter START. Otherwise it SHALL return to IDLE.
- REQ-018 Bytes SHALL be sent least-significant byte first: byte k = data[8k+7:8k].
- REQ-019 busy SHALL be 1 in every state except IDLE.
- REQ-020 An IDLE cycle SHALL separate consecutive words, so the minimum word-to-word pop spacing is BytesPerWord x frame length + 1 cycles.
- REQ-021 A change of data or have_next during transmission SHALL NOT affect the frame in flight.
- REQ-022 If have_next=0 in IDLE, the block SHALL stay in IDLE with tx=1 and next=0 indefinitely.

Reset
- REQ-023 While reset_i=0, the block SHALL force the state to IDLE, tx=1, next=0, busy=0, and clear the baud counter, bit index, byte index, and shift register.
- REQ-024 Asserting reset mid-frame SHALL abort the frame immediately, with tx=1 asynchronously. After release, the block SHALL wait in IDLE and SHALL NOT re-pop the aborted word.

Configuration
- REQ-025 Macro UART_TX_PARITY_EN.
  - Defined: the block SHALL insert a PARITY bit between DATA and STOP, carrying even parity (XOR of the 8 data bits), so a frame is 11 bits.
  - Undefined: the PARITY state and logic SHALL be absent, and a frame SHALL be 10 bits (8N1).

Verification
- REQ-026 BaudDiv=4, BytesPerWord=1, macro undefined, data=0x000000A5, have_next pulses high in IDLE -> next high 1 cycle; tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high 40 cycles, then IDLE.
- REQ-027 Same as REQ-026 with BytesPerWord=4, data=0x11223344 -> bytes 0x44,0x33,0x22,0x11 in order; exactly one next pulse; busy high 160 cycles.
- REQ-028 UART_TX_PARITY_EN defined, BaudDiv=4, data=0x07 -> parity bit 1 after data bits; frame 44 cycles. data=0x03 -> parity bit 0.
- REQ-029 have_next held at 1 continuously with two queued words -> exactly two next pulses, separated by 41 cycles (BaudDiv=4, 1 byte); never back-to-back.
- REQ-030 reset_i driven low during bit 3 of the DATA state -> tx=1 within the same cycle, busy=0, next=0. After release with have_next=0, tx stays 1 with no further activity.
